// File: rtl/regfile_nrnw_clr_pkg.sv
// ============================================================================
// Module : regfile_nrnw_clr_pkg
// Brief  : Shared types and helpers for the multi-port clearing register file.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_nrnw_clr_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int MAX_WR   = 2;
    localparam int WR_IDX_W = 1;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_sel_t;

    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction

    function automatic int slice_lo(input int port, input int w);
        return port * w;
    endfunction

    // Scanning upward lets the highest-indexed hitting port win.
    function automatic wr_sel_t wr_resolve(input logic [MAX_WR-1:0] hits);
        wr_sel_t sel;
        sel = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (hits[j]) begin
                sel.hit = 1'b1;
                sel.idx = WR_IDX_W'(j);
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_nrnw_clr_if.sv
// ============================================================================
// Module : regfile_nrnw_clr_if
// Brief  : Read/write/clear bus of the multi-port register file.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_nrnw_clr_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic                         clear_req;
    logic                         ready;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*DEPTH_LOG2-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]      rd_data;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*DEPTH_LOG2-1:0] wr_addr;
    logic [NUM_WR*WIDTH-1:0]      wr_data;

    modport master (
        output clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ready, rd_data
    );

    modport slave (
        input  clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ready, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_nrnw_clr_seq.sv
// ============================================================================
// Module : regfile_nrnw_clr_seq
// Brief  : Clear sequencer; walks every entry after reset or clear request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_nrnw_clr_seq
    import regfile_nrnw_clr_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clear_req_i,
    output logic                       ready_o,
    output logic                       clr_we_o,
    output logic [DEPTH_LOG2-1:0]      clr_addr_o
);

    state_e                state_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic                  ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = ~ready_q;
    assign clr_addr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/regfile_nrnw_clr.sv
// ============================================================================
// Module : regfile_nrnw_clr
// Brief  : NUM_RD x NUM_WR register file with write-first bypass and clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_nrnw_clr
    import regfile_nrnw_clr_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    regfile_nrnw_clr_if.slave  bus
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam bit ZR    = (ZERO_REG != 0);

    logic                  ready;
    logic                  clr_we;
    logic [DEPTH_LOG2-1:0] clr_addr;
    logic                  wr_accept;

    regfile_nrnw_clr_seq #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req_i (bus.clear_req),
        .ready_o     (ready),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign bus.ready = ready;
    // A clear request wins over writes presented in the same cycle.
    assign wr_accept = ready & ~bus.clear_req;

    logic [DEPTH_LOG2-1:0] wa [MAX_WR];
    logic [WIDTH-1:0]      wd [MAX_WR];
    logic [MAX_WR-1:0]     wv;

    for (genvar j = 0; j < MAX_WR; j++) begin : g_wr
        if (j < NUM_WR) begin : g_used
            assign wa[j] = bus.wr_addr[slice_lo(j, DEPTH_LOG2) +: DEPTH_LOG2];
            assign wd[j] = bus.wr_data[slice_lo(j, WIDTH) +: WIDTH];
            assign wv[j] = bus.wr_en[j] & wr_accept & ~(ZR && (wa[j] == '0));
        end else begin : g_pad
            assign wa[j] = '0;
            assign wd[j] = '0;
            assign wv[j] = 1'b0;
        end
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic [MAX_WR-1:0] ent_hit;
        wr_sel_t           ent_sel;

        for (genvar j = 0; j < MAX_WR; j++) begin : g_hit
            assign ent_hit[j] = wv[j] && (wa[j] == DEPTH_LOG2'(e));
        end
        assign ent_sel = wr_resolve(ent_hit);

        always_ff @(posedge clk) begin
            if (clr_we && (clr_addr == DEPTH_LOG2'(e))) begin
                mem_q[e] <= '0;
            end else if (ent_sel.hit) begin
                mem_q[e] <= wd[ent_sel.idx];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DEPTH_LOG2-1:0] ra;
        logic [MAX_WR-1:0]     byp_hit;
        wr_sel_t               byp_sel;
        logic [WIDTH-1:0]      rdata_d;
        logic [WIDTH-1:0]      rdata_q;

        assign ra = bus.rd_addr[slice_lo(i, DEPTH_LOG2) +: DEPTH_LOG2];

        for (genvar j = 0; j < MAX_WR; j++) begin : g_byp
            assign byp_hit[j] = wv[j] && (wa[j] == ra);
        end
        assign byp_sel = wr_resolve(byp_hit);

        always_comb begin
            rdata_d = mem_q[ra];
            if (byp_sel.hit) begin
                rdata_d = wd[byp_sel.idx];
            end
            if (ZR && (ra == '0)) begin
                rdata_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (!ready) begin
                rdata_q <= '0;
            end else if (bus.rd_en[i]) begin
                rdata_q <= rdata_d;
            end
        end

        assign bus.rd_data[slice_lo(i, WIDTH) +: WIDTH] = rdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_nrnw_clr.sv
// ============================================================================
// Module : tb_regfile_nrnw_clr
// Brief  : Scoreboard bench; two DUTs (ZERO_REG 1 and 0) share one stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_nrnw_clr;

    localparam int W  = 32;
    localparam int AL = 4;
    localparam int D  = 16;

    logic clk;
    logic rst_n;

    regfile_nrnw_clr_if #(.WIDTH(W), .DEPTH_LOG2(AL), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_nrnw_clr_if #(.WIDTH(W), .DEPTH_LOG2(AL), .NUM_RD(2), .NUM_WR(2)) bus_b ();

    regfile_nrnw_clr #(
        .WIDTH(W), .DEPTH_LOG2(AL), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    regfile_nrnw_clr #(
        .WIDTH(W), .DEPTH_LOG2(AL), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus variables for the upcoming edge.
    logic          s_rst_n;
    logic          s_creq;
    logic [1:0]    s_we;
    logic [1:0]    s_re;
    logic [AL-1:0] s_wa [2];
    logic [AL-1:0] s_ra [2];
    logic [W-1:0]  s_wd [2];

    // Reference model: contents, remaining clear cycles, read registers.
    logic [W-1:0]  m_mem  [2][D];
    int            m_left [2];
    logic [W-1:0]  m_rd   [2][2];

    typedef struct packed {
        logic [1:0]          rdy;
        logic [1:0][1:0][W-1:0] rd;
    } exp_t;

    exp_t q_exp[$];
    exp_t m_e;

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        exp_t          e;
        logic [W-1:0]  nm [D];
        bit            zero;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            zero = (d == 0);
            if (!s_rst_n) begin
                m_left[d]   = D;
                m_rd[d][0]  = '0;
                m_rd[d][1]  = '0;
            end else if (m_left[d] != 0) begin
                m_mem[d][D - m_left[d]] = '0;
                m_left[d]  = m_left[d] - 1;
                m_rd[d][0] = '0;
                m_rd[d][1] = '0;
            end else begin
                for (int k = 0; k < D; k++) nm[k] = m_mem[d][k];
                if (!s_creq) begin
                    for (int j = 0; j < 2; j++)
                        if (s_we[j] && !(zero && s_wa[j] == 0)) nm[s_wa[j]] = s_wd[j];
                end
                for (int i = 0; i < 2; i++)
                    if (s_re[i]) m_rd[d][i] = (zero && s_ra[i] == 0) ? '0 : nm[s_ra[i]];
                for (int k = 0; k < D; k++) m_mem[d][k] = nm[k];
                if (s_creq) m_left[d] = D;
            end
            e.rdy[d]   = (m_left[d] == 0);
            e.rd[d][0] = m_rd[d][0];
            e.rd[d][1] = m_rd[d][1];
        end
        q_exp.push_back(e);
    endtask

    task automatic idle();
        s_creq = 1'b0;
        s_we   = '0;
        s_re   = '0;
        for (int j = 0; j < 2; j++) begin
            s_wa[j] = '0;
            s_ra[j] = '0;
            s_wd[j] = '0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rst_n           = s_rst_n;
        bus_a.clear_req = s_creq;
        bus_a.wr_en     = s_we;
        bus_a.wr_addr   = {s_wa[1], s_wa[0]};
        bus_a.wr_data   = {s_wd[1], s_wd[0]};
        bus_a.rd_en     = s_re;
        bus_a.rd_addr   = {s_ra[1], s_ra[0]};
        bus_b.clear_req = s_creq;
        bus_b.wr_en     = s_we;
        bus_b.wr_addr   = {s_wa[1], s_wa[0]};
        bus_b.wr_data   = {s_wd[1], s_wd[0]};
        bus_b.rd_en     = s_re;
        bus_b.rd_addr   = {s_ra[1], s_ra[0]};
        model_step();
    endtask

    task automatic read_all();
        for (int a = 0; a < D; a++) begin
            idle();
            s_re    = 2'b11;
            s_ra[0] = AL'(a);
            s_ra[1] = AL'(D - 1 - a);
            cyc();
        end
        idle();
    endtask

    always @(posedge clk) begin
        #1;
        if (q_exp.size() != 0) begin
            m_e = q_exp.pop_front();
            chk("a.ready", W'(bus_a.ready), W'(m_e.rdy[0]));
            chk("a.rd0",   bus_a.rd_data[W-1:0],   m_e.rd[0][0]);
            chk("a.rd1",   bus_a.rd_data[2*W-1:W], m_e.rd[0][1]);
            chk("b.ready", W'(bus_b.ready), W'(m_e.rdy[1]));
            chk("b.rd0",   bus_b.rd_data[W-1:0],   m_e.rd[1][0]);
            chk("b.rd1",   bus_b.rd_data[2*W-1:W], m_e.rd[1][1]);
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus_a.clear_req = 1'b0; bus_a.wr_en = '0; bus_a.rd_en = '0;
        bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
        bus_b.clear_req = 1'b0; bus_b.wr_en = '0; bus_b.rd_en = '0;
        bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = '0;
        for (int d = 0; d < 2; d++) begin
            m_left[d] = D;
            m_rd[d][0] = '0;
            m_rd[d][1] = '0;
            for (int k = 0; k < D; k++) m_mem[d][k] = '0;
        end
        idle();

        // Reset, release and full clear, then everything reads zero.
        s_rst_n = 1'b0;
        repeat (3) cyc();
        s_rst_n = 1'b1;
        repeat (20) cyc();
        read_all();

        // Plain write then delayed read on port 1, then hold.
        s_we = 2'b01; s_wa[0] = 4'd5; s_wd[0] = 32'hDEADBEEF; cyc(); idle();
        s_re = 2'b10; s_ra[1] = 4'd5; cyc(); idle();
        repeat (3) cyc();

        // Same-edge bypass.
        s_we = 2'b01; s_wa[0] = 4'd7; s_wd[0] = 32'h12345678;
        s_re = 2'b01; s_ra[0] = 4'd7; cyc(); idle();
        cyc();

        // Two-port collision with bypass, then readback.
        s_we = 2'b11; s_wa[0] = 4'd3; s_wa[1] = 4'd3;
        s_wd[0] = 32'hAAAA0000; s_wd[1] = 32'h5555FFFF;
        s_re = 2'b01; s_ra[0] = 4'd3; cyc(); idle();
        s_re = 2'b11; s_ra[0] = 4'd3; s_ra[1] = 4'd3; cyc(); idle();

        // Entry 0 write with bypass, then readback.
        s_we = 2'b01; s_wa[0] = 4'd0; s_wd[0] = 32'hFFFFFFFF;
        s_re = 2'b01; s_ra[0] = 4'd0; cyc(); idle();
        s_re = 2'b11; cyc(); idle();

        // Fill, then clear request together with a write and bypass read.
        for (int a = 1; a < D; a++) begin
            s_we = 2'b01; s_wa[0] = AL'(a); s_wd[0] = $urandom | 32'h1; cyc();
        end
        idle();
        s_creq = 1'b1; s_we = 2'b01; s_wa[0] = 4'd2; s_wd[0] = 32'hCAFEF00D;
        s_re = 2'b11; s_ra[0] = 4'd2; s_ra[1] = 4'd1; cyc(); idle();
        repeat (18) cyc();
        read_all();

        // Reset in the middle of a clear restarts the full sequence.
        s_creq = 1'b1; cyc(); idle();
        repeat (5) cyc();
        s_rst_n = 1'b0; cyc();
        s_rst_n = 1'b1;
        repeat (20) cyc();

        // Randomized traffic including occasional clears and resets.
        repeat (600) begin
            s_rst_n = ($urandom_range(0, 199) != 0);
            s_creq  = ($urandom_range(0, 39) == 0);
            s_we    = 2'($urandom);
            s_re    = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                s_wa[j] = AL'($urandom);
                s_ra[j] = AL'($urandom);
                s_wd[j] = $urandom;
            end
            cyc();
        end
        s_rst_n = 1'b1;
        idle();
        repeat (20) cyc();
        read_all();
        cyc();

        @(posedge clk);
        #2;
        chk("queue_drained", W'(q_exp.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_nrnw_clr.md
Name: regfile_nrnw_clr

Overview:
- Parametrised multi-port register file: NUM_RD synchronous read ports and NUM_WR write ports.
- Write-to-read bypass; optional hardwired-zero entry 0.
- Built-in clear sequencer zeroes every entry after reset or on request.
- Successor to the fixed 2R1W regfile; used as the integer/scalar register file of the core pipeline.

Parameters:
- WIDTH, 32, data bits per entry.
- DEPTH_LOG2, 4, address bits; DEPTH = 2**DEPTH_LOG2 entries.
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 1, write ports (1..2).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  pulse; re-run the clear sequence.
- ready  out  1  1 = array valid and accepting writes.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*DEPTH_LOG2  port i at bits [i*DEPTH_LOG2 +: DEPTH_LOG2].
- rd_data  out  NUM_RD*WIDTH  registered read data; port i at [i*WIDTH +: WIDTH].
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*DEPTH_LOG2  write addresses, packed as rd_addr.
- wr_data  in  NUM_WR*WIDTH  write data, packed as rd_data.

Behaviour:
- One clock clk; reset rst_n asynchronous, active-low.
- rst_n low: state=CLEAR, clr_ptr=0, ready=0, all rd_data=0. Storage array is not reset directly; it is zeroed by the sequencer.
- FSM states:
  - CLEAR: writes 0 to entry clr_ptr each cycle, clr_ptr++. On clr_ptr==DEPTH-1 -> RUN next cycle.
  - RUN: normal operation.
- Timing: first CLEAR write occurs on the first clk edge after rst_n rises. ready=1 from cycle DEPTH onward (DEPTH cycles of clearing).
- clear_req:
  - Sampled in RUN: -> CLEAR next cycle; clr_ptr=0; ready drops the same edge.
  - Sampled in CLEAR: ignored (no restart).
- Writes:
  - Performed at the clk edge when wr_en[j]=1 and ready=1.
  - Ignored while ready=0, including in the cycle clear_req is accepted.
  - ZERO_REG=1: writes to address 0 dropped.
  - Two write ports, same address: higher port index wins.
- Reads:
  - rd_en[i]=1 at edge t -> rd_data[i] reflects entry rd_addr[i] after edge t (1-cycle latency).
  - rd_en[i]=0: rd_data[i] holds its previous value.
  - ready=0: rd_data forced to 0 at each edge regardless of rd_en.
- Bypass (write-first): if an accepted write targets the read address at the same edge, rd_data shows the new wr_data. Multi-write collision follows the same priority.
- ZERO_REG=1 and rd_addr==0: rd_data=0 regardless of bypass.
- All read ports are independent; identical addresses on several ports are legal.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to the reset state above; sequence restarts from clr_ptr=0.

Decomposition:
- Package regfile_pkg:
  - State enum (CLEAR, RUN).
  - Helper localparams: DEPTH, port-slice offsets.
  - Function for write-priority resolve.
- Sub-module regfile_clr_seq: FSM, clr_ptr counter, ready, clear_req handling. Outputs the clear write enable/address to the array.
- Top level holds the storage array, write-merge logic, bypass muxes and read registers; read ports are generated per port.

Test Plan:
- Reset, DEPTH=16: release rst_n -> ready=0 for 16 cycles, ready=1 at cycle 16; then reading all 16 addresses on both ports returns 0.
- Basic write/read: write 0xDEADBEEF to addr 5, read addr 5 next cycle on port 1 -> rd_data[1]=0xDEADBEEF one cycle after rd_en. Drop rd_en -> value holds.
- Bypass: same edge wr_en=1 addr 7 data 0x12345678 and rd_en[0]=1 addr 7 -> rd_data[0]=0x12345678 after that edge.
- NUM_WR=2 collision: port0 writes 0xAAAA0000 and port1 writes 0x5555FFFF to addr 3 -> subsequent read of 3 = 0x5555FFFF; bypass in the same cycle also shows 0x5555FFFF.
- ZERO_REG: write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0, including the bypass cycle. With ZERO_REG=0 -> returns 0xFFFFFFFF.
- clear_req mid-run: fill addr 1..15 with nonzero, pulse clear_req together with a write to addr 2 -> ready low 16 cycles, write dropped, all entries read 0 after ready returns. Assert rst_n low during CLEAR -> sequence restarts and takes a full 16 cycles.
